// File: rtl/vacc_i8v4_i16v4_pkg.sv
// Shared definitions for the lane-wise window accumulator: lane count,
// input lane width, FSM state type and the input sign-extension helper.
package vacc_pkg;

  localparam int LANES = 4;
  localparam int LW    = 8;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  // Widen an input lane to the largest legal accumulator width; callers
  // narrow the result to their own AW with a size cast.
  function automatic logic signed [31:0] sext(input logic signed [LW-1:0] x);
    return 32'(x);
  endfunction

endpackage

// File: rtl/vacc_i8v4_i16v4_if.sv
// Stream bundle between the difference stage and the window accumulator:
// input vector handshake plus the summed-vector output handshake.
interface vacc_i8v4_i16v4_if #(
  parameter int AW = 16
);
  import vacc_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [LW-1:0] y_0;
  logic signed [LW-1:0] y_1;
  logic signed [LW-1:0] y_2;
  logic signed [LW-1:0] y_3;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] acc_0;
  logic signed [AW-1:0] acc_1;
  logic signed [AW-1:0] acc_2;
  logic signed [AW-1:0] acc_3;

  modport master (
    output in_valid, y_0, y_1, y_2, y_3, out_ready,
    input  in_ready, out_valid, acc_0, acc_1, acc_2, acc_3
  );

  modport slave (
    input  in_valid, y_0, y_1, y_2, y_3, out_ready,
    output in_ready, out_valid, acc_0, acc_1, acc_2, acc_3
  );

endinterface

// File: rtl/vacc_i8v4_i16v4_lane.sv
// One accumulator lane: loads a sign-extended sample to open a window and
// adds further samples with wrap-around arithmetic.
module vacc_lane
  import vacc_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 add,
  input  logic signed [LW-1:0] din,
  output logic signed [AW-1:0] q
);

  logic signed [AW-1:0] ext;

  assign ext = AW'(sext(din));

  // Lane register: load wins over add; otherwise hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= ext;
    end else if (add) begin
      q <= q + ext;
    end
  end

endmodule

// File: rtl/vacc_i8v4_i16v4.sv
// Lane-wise streaming accumulator: sums LEN consecutive difference vectors
// per lane and presents the window sum on a valid/ready output. A vector
// accepted during the output handshake opens the next window, so windows
// stream back-to-back without a bubble.
module vacc_i8v4_i16v4
  import vacc_pkg::*;
#(
  parameter int LEN = 4,
  parameter int AW  = 16
) (
  input logic              clock,
  input logic              reset,
  vacc_i8v4_i16v4_if.slave bus
);

  localparam logic [7:0] LAST = 8'(LEN - 1);

  state_t               state, state_nx;
  logic [7:0]           cnt, cnt_nx;
  logic                 ready_en;
  logic                 load, add;
  logic                 accept, take;
  logic signed [LW-1:0] y [LANES];
  logic signed [AW-1:0] q [LANES];

  assign y[0] = bus.y_0;
  assign y[1] = bus.y_1;
  assign y[2] = bus.y_2;
  assign y[3] = bus.y_3;

  // ready_en keeps in_ready low until the first clock edge after reset.
  assign bus.in_ready  = ready_en & ((state == ACC) | bus.out_ready);
  assign bus.out_valid = (state == OUT);
  assign accept        = bus.in_valid & bus.in_ready;
  assign take          = bus.out_valid & bus.out_ready;

  // State, window counter and post-reset ready enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ACC;
      cnt      <= '0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      ready_en <= 1'b1;
    end
  end

  // Next-state, counter and lane load/add decode.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    add      = 1'b0;
    case (state)
      ACC: begin
        if (accept) begin
          if (cnt == '0) load = 1'b1;
          else           add  = 1'b1;
          if (cnt == LAST) begin
            state_nx = OUT;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end
      end
      OUT: begin
        if (take) begin
          if (accept) begin
            load = 1'b1;
            if (LEN == 1) begin
              state_nx = OUT;
              cnt_nx   = '0;
            end else begin
              state_nx = ACC;
              cnt_nx   = 8'd1;
            end
          end else begin
            state_nx = ACC;
            cnt_nx   = '0;
          end
        end
      end
      default: begin
        state_nx = ACC;
        cnt_nx   = '0;
      end
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vacc_lane #(.AW(AW)) u_lane (
      .clock (clock),
      .reset (reset),
      .load  (load),
      .add   (add),
      .din   (y[i]),
      .q     (q[i])
    );
  end

  assign bus.acc_0 = q[0];
  assign bus.acc_1 = q[1];
  assign bus.acc_2 = q[2];
  assign bus.acc_3 = q[3];

endmodule

// File: tb/tb_vacc_i8v4_i16v4.sv
// Bench for the window accumulator: a LEN=4/AW=16 instance checked every
// cycle against a window-sum model, plus LEN=2/AW=8 and LEN=1 instances
// exercised with directed vectors.
module tb_vacc_i8v4_i16v4;

  localparam int LEN_A = 4;
  localparam int AW_A  = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clock = ~clock;

  vacc_i8v4_i16v4_if #(.AW(AW_A)) ifa ();
  vacc_i8v4_i16v4_if #(.AW(8))    ifb ();
  vacc_i8v4_i16v4_if #(.AW(16))   ifc ();

  vacc_i8v4_i16v4 #(.LEN(LEN_A), .AW(AW_A)) dut_a (.clock(clock), .reset(reset), .bus(ifa));
  vacc_i8v4_i16v4 #(.LEN(2),     .AW(8))    dut_b (.clock(clock), .reset(reset), .bus(ifb));
  vacc_i8v4_i16v4 #(.LEN(1),     .AW(16))   dut_c (.clock(clock), .reset(reset), .bus(ifc));

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint wrap_a(input longint v);
    longint r;
    r = v % 65536;
    if (r < 0) r += 65536;
    if (r >= 32768) r -= 65536;
    return r;
  endfunction

  // Window-sum model for dut_a, compared on every falling edge.
  longint part [4];
  longint pend [4];
  int     n_acc   = 0;
  bit     pending = 0;
  bit     alive   = 0;

  always @(negedge clock) begin
    longint ya [4];
    longint aa [4];
    bit     exp_rdy;
    ya[0] = longint'(ifa.y_0); ya[1] = longint'(ifa.y_1);
    ya[2] = longint'(ifa.y_2); ya[3] = longint'(ifa.y_3);
    aa[0] = longint'(ifa.acc_0); aa[1] = longint'(ifa.acc_1);
    aa[2] = longint'(ifa.acc_2); aa[3] = longint'(ifa.acc_3);
    if (!reset) begin
      check("a_rst_in_ready", ifa.in_ready, 0);
      check("a_rst_out_valid", ifa.out_valid, 0);
      for (int l = 0; l < 4; l++) check($sformatf("a_rst_acc%0d", l), aa[l], 0);
      for (int l = 0; l < 4; l++) part[l] = 0;
      n_acc   = 0;
      pending = 0;
      alive   = 0;
    end else begin
      exp_rdy = alive && (!pending || ifa.out_ready);
      check("a_in_ready", ifa.in_ready, exp_rdy);
      check("a_out_valid", ifa.out_valid, pending);
      if (pending)
        for (int l = 0; l < 4; l++) check($sformatf("a_acc%0d", l), aa[l], pend[l]);
      if (pending && ifa.out_ready) pending = 0;
      if (exp_rdy && ifa.in_valid) begin
        for (int l = 0; l < 4; l++) part[l] += ya[l];
        n_acc++;
        if (n_acc == LEN_A) begin
          for (int l = 0; l < 4; l++) begin
            pend[l] = wrap_a(part[l]);
            part[l] = 0;
          end
          pending = 1;
          n_acc   = 0;
        end
      end
      alive = 1;
    end
  end

  task automatic set_a(input int v0, input int v1, input int v2, input int v3);
    ifa.y_0 = 8'(v0); ifa.y_1 = 8'(v1); ifa.y_2 = 8'(v2); ifa.y_3 = 8'(v3);
  endtask

  // Present one vector on dut_a and wait (bounded) until it is accepted.
  task automatic push_a(input int v0, input int v1, input int v2, input int v3);
    bit got;
    int guard;
    got   = 0;
    guard = 0;
    set_a(v0, v1, v2, v3);
    ifa.in_valid = 1'b1;
    while (!got && guard < 50) begin
      @(negedge clock);
      got = ifa.in_ready;
      @(posedge clock); #1;
      guard++;
    end
    check("a_push_accepted", got, 1);
  endtask

  task automatic lit_a(input string name, input int e0, input int e1, input int e2, input int e3);
    check({name, "_v"}, ifa.out_valid, 1);
    check({name, "_0"}, longint'(ifa.acc_0), e0);
    check({name, "_1"}, longint'(ifa.acc_1), e1);
    check({name, "_2"}, longint'(ifa.acc_2), e2);
    check({name, "_3"}, longint'(ifa.acc_3), e3);
  endtask

  initial begin
    int nres;
    int vc [3][4];
    vc = '{'{-7, 100, -128, 5}, '{3, -1, 0, 127}, '{-100, 50, -50, 1}};
    ifa.in_valid = 0; ifa.out_ready = 1; set_a(0, 0, 0, 0);
    ifb.in_valid = 0; ifb.out_ready = 1; ifb.y_0 = 0; ifb.y_1 = 0; ifb.y_2 = 0; ifb.y_3 = 0;
    ifc.in_valid = 0; ifc.out_ready = 1; ifc.y_0 = 0; ifc.y_1 = 0; ifc.y_2 = 0; ifc.y_3 = 0;

    // Reset values.
    @(negedge clock);
    check("lit_rst_in_ready", ifa.in_ready, 0);
    check("lit_rst_out_valid", ifa.out_valid, 0);
    check("lit_rst_acc0", longint'(ifa.acc_0), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1;
    @(negedge clock);
    check("lit_first_cycle_in_ready", ifa.in_ready, 0);
    @(posedge clock); #1;

    // Steady stream.
    for (int k = 0; k < 4; k++) push_a(-5, -1, 2, 0);
    ifa.in_valid = 0;
    @(negedge clock);
    lit_a("lit_steady", -20, -4, 8, 0);
    @(posedge clock); #1;

    // Backpressure for 3 cycles.
    ifa.out_ready = 0;
    for (int k = 0; k < 4; k++) push_a(-5, -1, 2, 0);
    ifa.in_valid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("lit_bp_in_ready", ifa.in_ready, 0);
      lit_a("lit_bp", -20, -4, 8, 0);
      @(posedge clock); #1;
    end
    ifa.out_ready = 1;
    @(negedge clock);
    check("lit_bp_release_valid", ifa.out_valid, 1);
    @(posedge clock); #1;
    @(negedge clock);
    check("lit_bp_after_valid", ifa.out_valid, 0);
    check("lit_bp_after_ready", ifa.in_ready, 1);
    @(posedge clock); #1;

    // Back-to-back windows.
    nres = 0;
    set_a(1, 2, 3, 4);
    ifa.in_valid = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      check("lit_b2b_in_ready", ifa.in_ready, 1);
      if (ifa.out_valid) begin
        nres++;
        lit_a("lit_b2b", 4, 8, 12, 16);
      end
      @(posedge clock); #1;
    end
    ifa.in_valid = 0;
    @(negedge clock);
    if (ifa.out_valid) begin
      nres++;
      lit_a("lit_b2b", 4, 8, 12, 16);
    end
    check("lit_b2b_results", nres, 2);
    @(posedge clock); #1;

    // Sign extension of extreme inputs.
    for (int k = 0; k < 4; k++) push_a(-128, -128, 127, 127);
    ifa.in_valid = 0;
    @(negedge clock);
    lit_a("lit_sext", -512, -512, 508, 508);
    @(posedge clock); #1;

    // Reset in the middle of a window.
    for (int k = 0; k < 2; k++) push_a(9, 9, 9, 9);
    ifa.in_valid = 0;
    reset = 0;
    @(negedge clock);
    check("lit_midrst_valid", ifa.out_valid, 0);
    @(posedge clock); #1;
    reset = 1;
    for (int k = 0; k < 4; k++) push_a(1, 1, 1, 1);
    ifa.in_valid = 0;
    @(negedge clock);
    lit_a("lit_midrst", 4, 4, 4, 4);
    @(posedge clock); #1;

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      ifa.in_valid  = ($urandom_range(0, 9) < 7);
      ifa.out_ready = ($urandom_range(0, 9) < 6);
      set_a($urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255));
      reset = ($urandom_range(0, 499) != 0);
      @(posedge clock); #1;
    end
    reset = 1;
    ifa.in_valid = 0;
    ifa.out_ready = 1;
    repeat (3) @(posedge clock);
    #1;

    // AW=8, LEN=2 wrap-around.
    ifb.y_0 = 8'sd127; ifb.y_1 = -8'sd128; ifb.y_2 = 8'sd100; ifb.y_3 = -8'sd1;
    ifb.in_valid = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check("b_in_ready", ifb.in_ready, 1);
      @(posedge clock); #1;
    end
    ifb.in_valid = 0;
    @(negedge clock);
    check("b_wrap_valid", ifb.out_valid, 1);
    check("b_wrap_0", longint'(ifb.acc_0), -2);
    check("b_wrap_1", longint'(ifb.acc_1), 0);
    check("b_wrap_2", longint'(ifb.acc_2), -56);
    check("b_wrap_3", longint'(ifb.acc_3), -2);
    @(posedge clock); #1;
    @(negedge clock);
    check("b_after_valid", ifb.out_valid, 0);
    @(posedge clock); #1;

    // LEN=1: every accept yields its own vector the next cycle.
    ifc.in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      ifc.y_0 = 8'(vc[k][0]); ifc.y_1 = 8'(vc[k][1]);
      ifc.y_2 = 8'(vc[k][2]); ifc.y_3 = 8'(vc[k][3]);
      @(negedge clock);
      check("c_in_ready", ifc.in_ready, 1);
      if (k > 0) begin
        check("c_valid", ifc.out_valid, 1);
        check("c_acc0", longint'(ifc.acc_0), vc[k-1][0]);
        check("c_acc3", longint'(ifc.acc_3), vc[k-1][3]);
      end
      @(posedge clock); #1;
    end
    ifc.in_valid = 0;
    @(negedge clock);
    check("c_last_valid", ifc.out_valid, 1);
    check("c_last_acc1", longint'(ifc.acc_1), vc[2][1]);
    check("c_last_acc2", longint'(ifc.acc_2), vc[2][2]);
    @(posedge clock); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
